// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases NUM_STAGES reset domains in order after power-on, and
// re-asserts them in reverse, holds, then re-releases them on an accepted soft reset.
module rst_seq_ctrl #(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 16,
  parameter int HOLD_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sw_rst_req,
  output logic                  sw_rst_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  sys_ready,
  output logic                  busy,
  output logic [1:0]            rst_cause,
  output logic [7:0]            soft_rst_cnt
);

  localparam int MAX_CNT = (STAGE_DELAY > HOLD_CYCLES) ? STAGE_DELAY : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [NUM_STAGES-1:0] STAGES_OFF = {NUM_STAGES{1'b0}};
  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_RUN     = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic [IDX_W-1:0]        idx_r;
  logic [IDX_W-1:0]        idx_nxt_s;
  logic [NUM_STAGES-1:0]   stage_r;
  logic [NUM_STAGES-1:0]   stage_nxt_s;
  logic [NUM_STAGES-1:0]   idx_bit_s;
  logic                    ack_r;
  logic                    ack_nxt_s;
  logic                    ready_r;
  logic                    ready_nxt_s;
  logic                    busy_r;
  logic                    busy_nxt_s;
  logic [1:0]              cause_r;
  logic [1:0]              cause_nxt_s;
  logic [7:0]              soft_cnt_r;
  logic [7:0]              soft_cnt_nxt_s;

  assign idx_bit_s = NUM_STAGES'(1) << idx_r;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_RELEASE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RELEASE: begin
        if ((cnt_r == STAGE_LAST) && (idx_r == IDX_LAST)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      ST_RUN: begin
        if (sw_rst_req) begin
          state_nxt_s = ST_ASSERT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_ASSERT: begin
        if (idx_r == IDX_ZERO) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_ASSERT;
        end
      end
      ST_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_RELEASE;
    endcase
  end

  // Next values of the counters and of every registered output.
  always_comb begin
    cnt_nxt_s      = cnt_r;
    idx_nxt_s      = idx_r;
    stage_nxt_s    = stage_r;
    ack_nxt_s      = 1'b0;
    cause_nxt_s    = cause_r;
    soft_cnt_nxt_s = soft_cnt_r;
    case (state_r)
      ST_RELEASE: begin
        if (cnt_r == STAGE_LAST) begin
          stage_nxt_s = stage_r | idx_bit_s;
          cnt_nxt_s   = CNT_ZERO;
          idx_nxt_s   = idx_r + IDX_ONE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (sw_rst_req) begin
          ack_nxt_s      = 1'b1;
          cause_nxt_s    = CAUSE_SOFT;
          soft_cnt_nxt_s = soft_cnt_r + 8'd1;
          idx_nxt_s      = IDX_LAST;
        end else begin
          ack_nxt_s = 1'b0;
        end
      end
      ST_ASSERT: begin
        // Highest stage goes down first so domains fall in reverse dependency order.
        stage_nxt_s = stage_r & ~idx_bit_s;
        if (idx_r == IDX_ZERO) begin
          cnt_nxt_s = CNT_ZERO;
        end else begin
          idx_nxt_s = idx_r - IDX_ONE;
        end
      end
      ST_HOLD: begin
        stage_nxt_s = STAGES_OFF;
        if (cnt_r == HOLD_LAST) begin
          cnt_nxt_s = CNT_ZERO;
          idx_nxt_s = IDX_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        stage_nxt_s = STAGES_OFF;
        cnt_nxt_s   = CNT_ZERO;
        idx_nxt_s   = IDX_ZERO;
      end
    endcase
    ready_nxt_s = (state_nxt_s == ST_RUN);
    busy_nxt_s  = (state_nxt_s != ST_RUN);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r      <= CNT_ZERO;
      idx_r      <= IDX_ZERO;
      stage_r    <= STAGES_OFF;
      ack_r      <= 1'b0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b1;
      cause_r    <= CAUSE_POR;
      soft_cnt_r <= 8'd0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      idx_r      <= idx_nxt_s;
      stage_r    <= stage_nxt_s;
      ack_r      <= ack_nxt_s;
      ready_r    <= ready_nxt_s;
      busy_r     <= busy_nxt_s;
      cause_r    <= cause_nxt_s;
      soft_cnt_r <= soft_cnt_nxt_s;
    end
  end

  assign sw_rst_ack   = ack_r;
  assign stage_rst_n  = stage_r;
  assign sys_ready    = ready_r;
  assign busy         = busy_r;
  assign rst_cause    = cause_r;
  assign soft_rst_cnt = soft_cnt_r;

  rst_seq_ctrl_chk #(
    .NUM_STAGES(NUM_STAGES)
  ) u_chk (
    .clk         (clk),
    .rst_n       (reset_n),
    .stage_rst_n (stage_r),
    .sys_ready   (ready_r),
    .busy        (busy_r),
    .sw_rst_ack  (ack_r)
  );

endmodule

// Invariants of the sequencer outputs.
module rst_seq_ctrl_chk #(
  parameter int NUM_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_STAGES-1:0] stage_rst_n,
  input  logic                  sys_ready,
  input  logic                  busy,
  input  logic                  sw_rst_ack
);

  logic [NUM_STAGES:0] therm_s;

  assign therm_s = {1'b0, stage_rst_n} + (NUM_STAGES + 1)'(1);

  a_ack_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    sw_rst_ack |=> !sw_rst_ack)
    else $error("sw_rst_ack held longer than one cycle");

  a_ready_all: assert property (@(posedge clk) disable iff (!rst_n)
    sys_ready |-> (&stage_rst_n))
    else $error("sys_ready with stage_rst_n=%b", stage_rst_n);

  a_busy_ready: assert property (@(posedge clk) disable iff (!rst_n)
    busy != sys_ready)
    else $error("busy and sys_ready disagree");

  // Released stages always form a contiguous run starting at bit 0.
  a_thermo: assert property (@(posedge clk) disable iff (!rst_n)
    ((therm_s[NUM_STAGES-1:0] & stage_rst_n) == {NUM_STAGES{1'b0}}))
    else $error("stage_rst_n out of order: %b", stage_rst_n);

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a timeline model predicts every output change,
// a monitor compares each change the DUT presents. Two instances: defaults and 1/1/1.
module tb_rst_seq_ctrl;

  localparam int NA = 3, SDA = 16, HCA = 32;
  localparam int NB = 1, SDB = 1,  HCB = 1;

  typedef struct packed {
    logic [7:0] stage;
    logic       ready;
    logic       busy;
    logic       ack;
    logic [1:0] cause;
    logic [7:0] cnt;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n_a, reset_n_b, req_a, req_b;
  logic          ack_a, ack_b, rdy_a, rdy_b, busy_a, busy_b;
  logic [NA-1:0] st_a;
  logic [NB-1:0] st_b;
  logic [1:0]    cause_a, cause_b;
  logic [7:0]    cnt_a, cnt_b;

  int tests = 0;
  int fails = 0;
  int cyc_a, cyc_b;
  exp_t q_a[$];
  exp_t q_b[$];
  snap_t prev_s[2];
  logic [7:0] cnt_m[2];
  int run_from[2];

  rst_seq_ctrl #(.NUM_STAGES(NA), .STAGE_DELAY(SDA), .HOLD_CYCLES(HCA)) u_dut_a (
    .clk(clk), .reset_n(reset_n_a), .sw_rst_req(req_a), .sw_rst_ack(ack_a),
    .stage_rst_n(st_a), .sys_ready(rdy_a), .busy(busy_a),
    .rst_cause(cause_a), .soft_rst_cnt(cnt_a));

  rst_seq_ctrl #(.NUM_STAGES(NB), .STAGE_DELAY(SDB), .HOLD_CYCLES(HCB)) u_dut_b (
    .clk(clk), .reset_n(reset_n_b), .sw_rst_req(req_b), .sw_rst_ack(ack_b),
    .stage_rst_n(st_b), .sys_ready(rdy_b), .busy(busy_b),
    .rst_cause(cause_b), .soft_rst_cnt(cnt_b));

  // Edge count since reset release: edge 1 is the first rising edge after deassertion.
  always @(posedge clk or negedge reset_n_a)
    if (!reset_n_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
  always @(posedge clk or negedge reset_n_b)
    if (!reset_n_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;

  function automatic int n_of(input int d);  return (d == 0) ? NA  : NB;  endfunction
  function automatic int sd_of(input int d); return (d == 0) ? SDA : SDB; endfunction
  function automatic int hc_of(input int d); return (d == 0) ? HCA : HCB; endfunction
  function automatic int cyc_of(input int d); return (d == 0) ? cyc_a : cyc_b; endfunction
  function automatic logic rst_of(input int d); return (d == 0) ? reset_n_a : reset_n_b; endfunction
  function automatic int qsize(input int d); return (d == 0) ? q_a.size() : q_b.size(); endfunction

  function automatic void qpush(input int d, input exp_t e);
    if (d == 0) q_a.push_back(e); else q_b.push_back(e);
  endfunction

  function automatic exp_t qpop(input int d);
    if (d == 0) return q_a.pop_front();
    return q_b.pop_front();
  endfunction

  function automatic void qclear(input int d);
    if (d == 0) q_a.delete(); else q_b.delete();
  endfunction

  function automatic snap_t snap_of(input int d);
    snap_t s;
    if (d == 0) s = {5'd0, st_a, rdy_a, busy_a, ack_a, cause_a, cnt_a};
    else        s = {7'd0, st_b, rdy_b, busy_b, ack_b, cause_b, cnt_b};
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("stage=%b rdy=%b busy=%b ack=%b cause=%b cnt=%0d",
                     s.stage, s.ready, s.busy, s.ack, s.cause, s.cnt);
  endfunction

  // Release phase starting at edge t0: stage k rises at t0+(k+1)*delay.
  task automatic push_release(input int d, input int t0, input logic [1:0] cause,
                              input logic [7:0] cnt);
    exp_t e;
    for (int k = 0; k < n_of(d); k++) begin
      e.cyc     = t0 + (k + 1) * sd_of(d);
      e.s.stage = 8'((1 << (k + 1)) - 1);
      e.s.ready = (k == n_of(d) - 1);
      e.s.busy  = (k != n_of(d) - 1);
      e.s.ack   = 1'b0;
      e.s.cause = cause;
      e.s.cnt   = cnt;
      qpush(d, e);
    end
    run_from[d] = t0 + n_of(d) * sd_of(d) + 1;
  endtask

  // Accept at edge a: ack, reverse assertion one stage per edge, hold, re-release.
  task automatic push_accept(input int d, input int a);
    exp_t e;
    cnt_m[d]  = cnt_m[d] + 8'd1;
    e.cyc     = a;
    e.s.stage = 8'((1 << n_of(d)) - 1);
    e.s.ready = 1'b0;
    e.s.busy  = 1'b1;
    e.s.ack   = 1'b1;
    e.s.cause = 2'b10;
    e.s.cnt   = cnt_m[d];
    qpush(d, e);
    for (int j = 1; j <= n_of(d); j++) begin
      e.cyc     = a + j;
      e.s.stage = 8'((1 << (n_of(d) - j)) - 1);
      e.s.ack   = 1'b0;
      qpush(d, e);
    end
    push_release(d, a + n_of(d) + hc_of(d), 2'b10, cnt_m[d]);
  endtask

  task automatic monitor(input int d);
    snap_t s;
    exp_t  e;
    s = snap_of(d);
    if (!rst_of(d)) begin
      prev_s[d] = s;
    end else if (s !== prev_s[d]) begin
      tests++;
      if (qsize(d) == 0) begin
        fails++;
        $display("FAIL out_change dut%0d: cycle %0d got %s, required no change",
                 d, cyc_of(d), fmt(s));
      end else begin
        e = qpop(d);
        if (e.cyc != cyc_of(d) || e.s !== s) begin
          fails++;
          $display("FAIL out_change dut%0d: cycle %0d got %s, required cycle %0d %s",
                   d, cyc_of(d), fmt(s), e.cyc, fmt(e.s));
        end
      end
      prev_s[d] = s;
    end
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
  end

  task automatic wait_until(input int d, input int x);
    while (cyc_of(d) < x) @(negedge clk);
  endtask

  task automatic drain(input int d, input int budget);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (qsize(d) != 0) begin
      fails++;
      $display("FAIL drain dut%0d: got %0d predicted changes still pending after %0d cycles, required 0",
               d, qsize(d), budget);
      qclear(d);
    end
  endtask

  task automatic do_reset(input int d);
    snap_t s, want;
    #2;
    if (d == 0) reset_n_a = 1'b0; else reset_n_b = 1'b0;
    #1;
    s    = snap_of(d);
    want = {8'd0, 1'b0, 1'b1, 1'b0, 2'b01, 8'd0};
    tests++;
    if (s !== want) begin
      fails++;
      $display("FAIL reset_state dut%0d: got %s, required %s", d, fmt(s), fmt(want));
    end
    qclear(d);
    cnt_m[d] = 8'd0;
    @(negedge clk);
    #1;
    if (d == 0) reset_n_a = 1'b1; else reset_n_b = 1'b1;
    push_release(d, 0, 2'b01, 8'd0);
  endtask

  task automatic soft_request(input int d, output int acc);
    int a;
    if (d == 0) req_a = 1'b1; else req_b = 1'b1;
    a = cyc_of(d) + 1;
    if (run_from[d] > a) a = run_from[d];
    push_accept(d, a);
    wait_until(d, a);
    if (d == 0) req_a = 1'b0; else req_b = 1'b0;
    acc = a;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no end of test, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    reset_n_a = 1'b1;
    reset_n_b = 1'b1;
    req_a     = 1'b0;
    req_b     = 1'b0;
    #1 reset_n_b = 1'b0;

    // Power-on sequence, then a single soft reset from RUN.
    do_reset(0);
    drain(0, 100);
    repeat ($urandom_range(1, 10)) @(negedge clk);
    soft_request(0, a);
    drain(0, 200);

    // Request raised during HOLD is only accepted once RUN is reached.
    soft_request(0, a);
    wait_until(0, a + NA + 5);
    soft_request(0, a);
    drain(0, 200);

    // Random request timing, often landing while a previous sequence is in flight.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 100)) @(negedge clk);
      soft_request(0, a);
    end
    drain(0, 200);

    // Async reset mid-ASSERT and mid-RELEASE.
    soft_request(0, a);
    wait_until(0, a + 1);
    do_reset(0);
    drain(0, 100);
    soft_request(0, a);
    wait_until(0, a + NA + HCA + SDA + 3);
    do_reset(0);
    drain(0, 100);

    // Request held high across 256 accepts: one ack per RUN entry, count wraps to 0.
    req_a = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = cyc_a + 1;
      if (run_from[0] > a) a = run_from[0];
      push_accept(0, a);
    end
    wait_until(0, a);
    req_a = 1'b0;
    drain(0, 300);
    tests++;
    if (cnt_a !== 8'd0) begin
      fails++;
      $display("FAIL wrap: got soft_rst_cnt=%0d, required 0", cnt_a);
    end

    // Minimal parameter set.
    do_reset(1);
    drain(1, 20);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      soft_request(1, a);
    end
    drain(1, 40);
    req_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = cyc_b + 1;
      if (run_from[1] > a) a = run_from[1];
      push_accept(1, a);
    end
    wait_until(1, a);
    req_b = 1'b0;
    drain(1, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
